// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared definitions for the multi-cycle RV64 control unit.
//   state_t      - control FSM states
//   Opc*         - supported major opcodes (instruction[6:0])
//   AluOp*       - alu_op encodings, also consumed by the ALU control decoder
//   AluSrcB*     - alu_src_b steering encodings
//   ctrl_t       - bundle of Moore control outputs
//   moore_ctrl() - Moore output values for a given state
package multicycle_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecute,
        StRWb,
        StMemAddr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StBranch,
        StHalt
    } state_t;

    localparam logic [6:0] OpcRtype = 7'b0110011;
    localparam logic [6:0] OpcLd    = 7'b0000011;
    localparam logic [6:0] OpcSd    = 7'b0100011;
    localparam logic [6:0] OpcBeq   = 7'b1100011;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] AluSrcBReg  = 2'b00;
    localparam logic [1:0] AluSrcBFour = 2'b01;
    localparam logic [1:0] AluSrcBImm  = 2'b10;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       halted;
    } ctrl_t;

    // Moore outputs per state; anything not set stays 0.
    function automatic ctrl_t moore_ctrl(state_t st);
        ctrl_t c;
        c = '0;
        unique case (st)
            StFetch: begin
                c.mem_read  = 1'b1;
                c.alu_src_a = 1'b0;
                c.alu_src_b = AluSrcBFour;
                c.alu_op    = AluOpAdd;
            end
            StDecode: begin
                // Branch target computed early into ALUOut.
                c.alu_src_a = 1'b0;
                c.alu_src_b = AluSrcBImm;
                c.alu_op    = AluOpAdd;
            end
            StExecute: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = AluSrcBReg;
                c.alu_op    = AluOpFunct;
            end
            StRWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b0;
            end
            StMemAddr: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = AluSrcBImm;
                c.alu_op    = AluOpAdd;
            end
            StMemRead: begin
                c.i_or_d   = 1'b1;
                c.mem_read = 1'b1;
            end
            StMemWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            StMemWrite: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            StBranch: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = AluSrcBReg;
                c.alu_op        = AluOpSub;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 1'b1;
            end
            StHalt: begin
                c.halted = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle RV64 datapath.
// Sequences fetch / decode / execute / memory / write-back, counts retired
// instructions and traps on unsupported opcodes.
// Ports:
//   clk, reset        - clock (rising edge), synchronous active-high reset
//   opcode            - instruction[6:0] from the IR, used in DECODE only
//   mem_ready         - memory finishes the current access this cycle
//   pc_write*, pc_source, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op - datapath controls
//   instret           - retired-instruction count (wraps)
//   halted            - sticky illegal-opcode trap flag
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [CNT_W-1:0] instret,
    output logic             halted
);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q;
    logic [6:0]       opcode_q;
    logic [CNT_W-1:0] instret_q;
    logic             retire;
    logic             fetch_ack;

    // Next state and retire strobe.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                case (opcode)
                    OpcRtype:      state_d = StExecute;
                    OpcLd, OpcSd:  state_d = StMemAddr;
                    OpcBeq:        state_d = StBranch;
                    default:       state_d = StHalt;
                endcase
            end
            StExecute: state_d = StRWb;
            StRWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StMemAddr: state_d = (opcode_q == OpcLd) ? StMemRead : StMemWrite;
            StMemRead: begin
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StMemWrite: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StBranch: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Moore outputs are registered from the next state so they track state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            ctrl_q    <= moore_ctrl(StFetch);
            opcode_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= moore_ctrl(state_d);
            if (state_q == StDecode) opcode_q <= opcode;
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    // IR and PC loads follow mem_ready combinationally during FETCH.
    assign fetch_ack = ~reset & (state_q == StFetch) & mem_ready;

    // Control outputs are forced low while reset is held, even mid-instruction.
    assign pc_write      = fetch_ack;
    assign ir_write      = fetch_ack;
    assign pc_write_cond = ~reset & ctrl_q.pc_write_cond;
    assign pc_source     = ~reset & ctrl_q.pc_source;
    assign i_or_d        = ~reset & ctrl_q.i_or_d;
    assign mem_read      = ~reset & ctrl_q.mem_read;
    assign mem_write     = ~reset & ctrl_q.mem_write;
    assign mem_to_reg    = ~reset & ctrl_q.mem_to_reg;
    assign reg_write     = ~reset & ctrl_q.reg_write;
    assign alu_src_a     = ~reset & ctrl_q.alu_src_a;
    assign alu_src_b     = reset ? 2'b00 : ctrl_q.alu_src_b;
    assign alu_op        = reset ? 2'b00 : ctrl_q.alu_op;
    assign instret       = instret_q;
    assign halted        = ctrl_q.halted;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed plus randomized bench for multicycle_control. The reference model
// expands each instruction into its expected per-cycle control words from the
// instruction class and the number of memory wait cycles.
module tb_multicycle_control;

    localparam int unsigned CW = 4;

    localparam int KR   = 0;
    localparam int KLD  = 1;
    localparam int KSD  = 2;
    localparam int KBEQ = 3;
    localparam int KILL = 4;

    // Field order: pcw pwc psrc iord mr mw irw m2r rw sa sb op halted
    localparam logic [14:0] WFWAIT = 15'b0_0_0_0_1_0_0_0_0_0_01_00_0;
    localparam logic [14:0] WFACK  = 15'b1_0_0_0_1_0_1_0_0_0_01_00_0;
    localparam logic [14:0] WDEC   = 15'b0_0_0_0_0_0_0_0_0_0_10_00_0;
    localparam logic [14:0] WEXE   = 15'b0_0_0_0_0_0_0_0_0_1_00_10_0;
    localparam logic [14:0] WRWB   = 15'b0_0_0_0_0_0_0_0_1_0_00_00_0;
    localparam logic [14:0] WMADDR = 15'b0_0_0_0_0_0_0_0_0_1_10_00_0;
    localparam logic [14:0] WMRD   = 15'b0_0_0_1_1_0_0_0_0_0_00_00_0;
    localparam logic [14:0] WMWB   = 15'b0_0_0_0_0_0_0_1_1_0_00_00_0;
    localparam logic [14:0] WMWR   = 15'b0_0_0_1_0_1_0_0_0_0_00_00_0;
    localparam logic [14:0] WBR    = 15'b0_1_1_0_0_0_0_0_0_1_00_01_0;
    localparam logic [14:0] WHALT  = 15'b0_0_0_0_0_0_0_0_0_0_00_00_1;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    opcode;
    logic          mem_ready;
    logic          pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
    logic          ir_write, mem_to_reg, reg_write, alu_src_a, halted;
    logic [1:0]    alu_src_b, alu_op;
    logic [CW-1:0] instret;

    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] model_instret = '0;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .instret       (instret),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, halted};
    endfunction

    function automatic logic [6:0] opc_of(input int kind);
        logic [6:0] o;
        case (kind)
            KR:      o = 7'b0110011;
            KLD:     o = 7'b0000011;
            KSD:     o = 7'b0100011;
            KBEQ:    o = 7'b1100011;
            default: begin
                o = 7'($urandom);
                while (o == 7'b0110011 || o == 7'b0000011 || o == 7'b0100011 ||
                       o == 7'b1100011)
                    o = 7'($urandom);
            end
        endcase
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // One clock: drive at +1 after posedge, check at negedge.
    task automatic cycle(input string tag, input logic rdy, input logic [6:0] opc,
                         input logic [14:0] exp);
        mem_ready = rdy;
        opcode    = opc;
        @(negedge clk);
        check({tag, " ctrl"}, 32'(obs()), 32'(exp));
        check({tag, " instret"}, 32'(instret), 32'(model_instret));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'($urandom);
        opcode    = 7'($urandom);
        @(posedge clk);
        #1;
        model_instret = '0;
        @(negedge clk);
        check("reset ctrl", 32'(obs()), 32'h0);
        check("reset instret", 32'(instret), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Expand one instruction into expected cycles, then play them.
    // abort_at >= 0 asserts reset in that cycle instead of completing.
    task automatic run_instr(input int kind, input int wf, input int wm, input int abort_at);
        logic [14:0] eq[$];
        logic        rq[$];
        logic [6:0]  opc;
        int          dec_idx;
        bit          retires;
        opc     = opc_of(kind);
        retires = (kind != KILL);
        for (int i = 0; i < wf; i++) begin eq.push_back(WFWAIT); rq.push_back(1'b0); end
        eq.push_back(WFACK); rq.push_back(1'b1);
        dec_idx = eq.size();
        eq.push_back(WDEC); rq.push_back(1'($urandom));
        case (kind)
            KR: begin
                eq.push_back(WEXE); rq.push_back(1'($urandom));
                eq.push_back(WRWB); rq.push_back(1'($urandom));
            end
            KLD: begin
                eq.push_back(WMADDR); rq.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin eq.push_back(WMRD); rq.push_back(1'b0); end
                eq.push_back(WMRD); rq.push_back(1'b1);
                eq.push_back(WMWB); rq.push_back(1'($urandom));
            end
            KSD: begin
                eq.push_back(WMADDR); rq.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin eq.push_back(WMWR); rq.push_back(1'b0); end
                eq.push_back(WMWR); rq.push_back(1'b1);
            end
            KBEQ: begin
                eq.push_back(WBR); rq.push_back(1'($urandom));
            end
            default: begin
                for (int i = 0; i < 20; i++) begin
                    eq.push_back(WHALT); rq.push_back(1'($urandom));
                end
            end
        endcase
        for (int i = 0; i < eq.size(); i++) begin
            if (i == abort_at) begin
                reset     = 1'b1;
                mem_ready = 1'b1;
                opcode    = 7'($urandom);
                @(negedge clk);
                check("abort ctrl", 32'(obs()), 32'h0);
                check("abort instret", 32'(instret), 32'(model_instret));
                @(posedge clk);
                #1;
                model_instret = '0;
                reset = 1'b0;
                check("abort cleared instret", 32'(instret), 32'h0);
                return;
            end
            cycle($sformatf("k%0d c%0d", kind, i), rq[i],
                  (i == dec_idx) ? opc : 7'($urandom), eq[i]);
        end
        if (retires) model_instret = model_instret + 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("held reset ctrl", 32'(obs()), 32'h0);
        check("held reset instret", 32'(instret), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(KR, 0, 0, -1);
        check("rtype retired", 32'(instret), 32'h1);
        run_instr(KLD, 0, 2, -1);
        run_instr(KSD, 0, 1, -1);
        run_instr(KBEQ, 0, 0, -1);
        check("four retired", 32'(instret), 32'h4);
        run_instr(KR, 2, 0, -1);
        run_instr(KILL, 0, 0, -1);
        check("halted sticky", 32'(halted), 32'h1);
        do_reset();
        check("halt cleared", 32'(halted), 32'h0);

        run_instr(KR, 0, 0, -1);
        run_instr(KLD, 0, 3, 5);

        while (model_instret != {CW{1'b1}}) run_instr(KR, 0, 0, -1);
        check("counter at max", 32'(instret), 32'((1 << CW) - 1));
        run_instr(KR, 0, 0, -1);
        check("counter wrapped", 32'(instret), 32'h0);

        for (int n = 0; n < 40; n++) begin
            int k;
            k = int'($urandom_range(0, 4));
            run_instr(k, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
            if (k == KILL) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multi-cycle RV64 datapath: a Moore/Mealy state machine that sequences each instruction through fetch, decode, execute, memory and write-back steps. It drives every datapath enable, steering mux and the 2-bit `alu_op` consumed by the ALU's control decoder. It sits beside the instruction register, which supplies `opcode`. It also keeps a retired-instruction counter and halts on unsupported opcodes.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  7  instruction[6:0] from the instruction register; sampled only in DECODE.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if ALU zero.
- `pc_source`  out  1  0 = ALU result, 1 = ALUOut register.
- `i_or_d`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  instruction register load.
- `mem_to_reg`  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = register B, 01 = constant 4, 10 = immediate.
- `alu_op`  out  2  00 = add, 01 = subtract, 10 = funct-decoded.
- `instret`  out  CNT_W  count of retired instructions.
- `halted`  out  1  illegal opcode trapped; sticky until reset.

## Operation
- **Supported opcodes:**
  - 0110011 R-type
  - 0000011 ld
  - 0100011 sd
  - 1100011 beq
- **Output defaults:** any output not listed for a state is 0.
- **States, outputs and transitions:**
  - FETCH: `mem_read`=1, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00. When `mem_ready`=1, also assert `ir_write`=1, `pc_write`=1 and `pc_source`=0, then go to DECODE. Otherwise stay in FETCH with `ir_write`/`pc_write` at 0.
  - DECODE: `alu_src_a`=0, `alu_src_b`=10, `alu_op`=00 (branch target into ALUOut). Next state by `opcode`:
    - R-type → EXECUTE
    - ld or sd → MEM_ADDR
    - beq → BRANCH
    - anything else → HALT
  - EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10 → R_WB.
  - R_WB: `reg_write`=1, `mem_to_reg`=0 → FETCH; retires.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state is MEM_READ if the latched opcode is ld, else MEM_WRITE.
  - MEM_READ: `i_or_d`=1, `mem_read`=1. Goes to MEM_WB on `mem_ready`, else holds.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1 → FETCH; retires.
  - MEM_WRITE: `i_or_d`=1, `mem_write`=1, held stable until `mem_ready`. Then → FETCH; retires.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=1 → FETCH; retires.
  - HALT: `halted`=1, all other control outputs 0. Stays in HALT until reset.
- **Opcode latch:** `opcode` is latched into an internal register in DECODE, so IR changes afterwards are ignored.
- **`instret`:** increments by 1 on each retiring transition into FETCH. Wraps modulo 2^CNT_W.
- **`mem_ready` scope:** ignored outside FETCH, MEM_READ and MEM_WRITE.

## Timing
- **Reset:**
  - While `reset`=1, all control outputs are 0, including `mem_read`.
  - On the reset edge: `instret`=0, `halted`=0, state=FETCH.
  - The first fetch request appears in the cycle after `reset` deasserts.
- **Reset priority:** reset mid-instruction (including during a memory wait) aborts the instruction. No retire and no further writes occur.
- **Cycles per instruction** with `mem_ready` high on first request:
  - R-type: 4
  - ld: 5
  - sd: 4
  - beq: 3
- **Wait states:** each cycle `mem_ready` is low in a memory state adds exactly one cycle.
- **Output timing:** Moore outputs change only on clock edges. `ir_write`/`pc_write` in FETCH are the only Mealy outputs, and they follow `mem_ready` combinationally.
- **Counter visibility:** `instret` updates on the same edge as the FETCH transition.

## Structure
- **Package `multicycle_pkg`:**
  - state enum (FETCH, DECODE, EXECUTE, R_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, HALT)
  - opcode constants
  - `alu_op` constants ADD=00, SUB=01, FUNCT=10, shared with the ALU
  - `alu_src_b` constants
- **Sub-modules:** none; one state register plus a combinational output/next-state block.

## Test plan
- Reset, then R-type opcode 0110011 with `mem_ready`=1 → states FETCH, DECODE, EXECUTE, R_WB. `alu_op`=10 in EXECUTE, `reg_write`=1 in R_WB, `instret`=1 after 4 cycles.
- ld with `mem_ready` low 2 cycles in MEM_READ → `mem_read`=1 and `i_or_d`=1 held 3 cycles. `mem_to_reg`=1 in MEM_WB. Total 7 cycles.
- sd with `mem_ready` low 1 cycle → `mem_write` stays 1 for 2 cycles, `reg_write` never asserts, `instret` +1.
- beq → `alu_op`=01, `pc_write_cond`=1, `pc_source`=1 in BRANCH. Back to FETCH after 3 cycles.
- Opcode 1111111 → HALT, `halted`=1, all control outputs 0 for 20 cycles. `reset` returns to FETCH with `halted`=0.
- `reset` asserted in MEM_READ wait → `instret` unchanged and outputs 0; `instret` preset to 2^CNT_W−1 via repeated R-type wraps to 0.
